// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer: FSM states, 7-segment
// digit codes and elaboration-time BCD helpers.
package timer_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

   // Segment codes, bit order {g,f,e,d,c,b,a}, active-high
   localparam logic [6:0] SEG_0    = 7'b0111111;
   localparam logic [6:0] SEG_1    = 7'b0000110;
   localparam logic [6:0] SEG_2    = 7'b1011011;
   localparam logic [6:0] SEG_3    = 7'b1001111;
   localparam logic [6:0] SEG_4    = 7'b1100110;
   localparam logic [6:0] SEG_5    = 7'b1101101;
   localparam logic [6:0] SEG_6    = 7'b1111101;
   localparam logic [6:0] SEG_7    = 7'b0000111;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1101111;
   localparam logic [6:0] SEG_DASH = 7'b1000000;

   function automatic int bcd_width(input int digits);
      return 4 * digits;
   endfunction

   // Up to 8 BCD digits; used to preload the display with the reload value
   function automatic logic [31:0] to_bcd(input int unsigned value);
      logic [31:0] r;
      int unsigned v;
      r = '0;
      v = value;
      for (int i = 0; i < 8; i++) begin
         r[i*4 +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter; one bit per clock.
// bcd holds the finished result while done is high.
module bin2bcd_seq
   import timer_pkg::*;
#(
   parameter int IN_W   = 8,
   parameter int DIGITS = 3
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic [IN_W-1:0]              bin,
   output logic                         busy,
   output logic                         done,
   output logic [bcd_width(DIGITS)-1:0] bcd
);

   localparam int BCD_W = bcd_width(DIGITS);
   localparam int CNT_W = $clog2(IN_W + 1);

   logic [IN_W-1:0]  bin_reg;
   logic [BCD_W-1:0] acc_reg;
   logic [BCD_W-1:0] acc_adj;
   logic [CNT_W-1:0] cnt_reg;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                     acc_reg[gi*4 +: 4] + 4'd3 : acc_reg[gi*4 +: 4];
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bin_reg <= '0;
         acc_reg <= '0;
         cnt_reg <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (busy) begin
            {acc_reg, bin_reg} <= {acc_adj, bin_reg} << 1;
            cnt_reg            <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end else if (start) begin
            bin_reg <= bin;
            acc_reg <= '0;
            cnt_reg <= CNT_W'(IN_W);
            busy    <= 1'b1;
         end
      end
   end

   assign bcd = acc_reg;

endmodule

// File: rtl/countdown_timer_sseg.sv
// Game countdown timer: prescaled tick counter with start/pause/penalty control
// and a multiplexed 7-segment driver fed by a sequential BCD converter.
module countdown_timer_sseg
   import timer_pkg::*;
#(
   parameter int TICK_DIV      = 5000,
   parameter int START_COUNT   = 1800000,
   parameter int PENALTY       = 100,
   parameter int NUM_DIGITS    = 8,
   parameter int DP_POS        = 4,
   parameter int SCAN_BITS     = 6,
   parameter int BLANK_LEADING = 0,
   localparam int COUNT_W      = $clog2(START_COUNT + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  penalty,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  game_over,
   output logic                  running,
   output logic [COUNT_W-1:0]    count
);

   localparam int BCD_W   = bcd_width(NUM_DIGITS);
   localparam int SEL_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PRESC_W = $clog2(TICK_DIV);
   localparam logic [31:0] START_BCD = to_bcd(START_COUNT);

   state_t               state_reg;
   logic [COUNT_W-1:0]   count_reg;
   logic [COUNT_W-1:0]   count_next;
   logic [PRESC_W-1:0]   presc_reg;
   logic                 running_reg;
   logic                 game_over_reg;
   logic [SCAN_BITS-1:0] scan_reg;
   logic [BCD_W-1:0]     digits_reg;
   logic [COUNT_W-1:0]   last_conv_reg;
   logic                 tick;
   logic                 pen_ok;
   logic [31:0]          dec_amt;
   logic                 conv_start;
   logic                 conv_busy;
   logic                 conv_done;
   logic [BCD_W-1:0]     conv_bcd;
   logic [SEL_W-1:0]     sel;
   logic [3:0]           nib;
   logic [NUM_DIGITS-1:0] blank_vec;

   // Tick and penalty share one saturating subtraction
   always_comb begin
      tick    = (state_reg == RUN) && (presc_reg == PRESC_W'(TICK_DIV - 1));
      pen_ok  = penalty && ((state_reg == RUN) || (state_reg == PAUSED));
      dec_amt = (tick ? 32'd1 : 32'd0) + (pen_ok ? 32'(PENALTY) : 32'd0);
      if (32'(count_reg) > dec_amt)
         count_next = COUNT_W'(32'(count_reg) - dec_amt);
      else
         count_next = '0;
   end

   // Expiry is taken the cycle after the count reads zero, ahead of pause/start
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         count_reg     <= COUNT_W'(START_COUNT);
         presc_reg     <= '0;
         running_reg   <= 1'b0;
         game_over_reg <= 1'b0;
      end else begin
         count_reg <= count_next;
         presc_reg <= '0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg   <= pause ? PAUSED : RUN;
                  running_reg <= !pause;
               end
            end
            RUN: begin
               if (count_reg == '0) begin
                  state_reg     <= EXPIRED;
                  running_reg   <= 1'b0;
                  game_over_reg <= 1'b1;
               end else if (pause) begin
                  state_reg   <= PAUSED;
                  running_reg <= 1'b0;
               end else begin
                  presc_reg <= tick ? '0 : presc_reg + PRESC_W'(1);
               end
            end
            PAUSED: begin
               if (count_reg == '0) begin
                  state_reg     <= EXPIRED;
                  game_over_reg <= 1'b1;
               end else if (start && !pause) begin
                  state_reg   <= RUN;
                  running_reg <= 1'b1;
               end
            end
            EXPIRED: begin
               if (start) begin
                  count_reg     <= COUNT_W'(START_COUNT);
                  state_reg     <= RUN;
                  running_reg   <= 1'b1;
                  game_over_reg <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign conv_start = !conv_busy && (count_reg != last_conv_reg);

   bin2bcd_seq #(
      .IN_W   (COUNT_W),
      .DIGITS (NUM_DIGITS)
   ) u_bin2bcd (
      .clock (clock),
      .reset (reset),
      .start (conv_start),
      .bin   (count_reg),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         scan_reg      <= '0;
         digits_reg    <= BCD_W'(START_BCD);
         last_conv_reg <= COUNT_W'(START_COUNT);
      end else begin
         scan_reg <= scan_reg + SCAN_BITS'(1);
         if (conv_start)
            last_conv_reg <= count_reg;
         if (conv_done)
            digits_reg <= conv_bcd;
      end
   end

   generate
      if (NUM_DIGITS > 1) begin : g_sel
         assign sel = scan_reg[SCAN_BITS-1 -: SEL_W];
      end else begin : g_sel_one
         assign sel = '0;
      end
   endgenerate

   // Leading-zero blanking walks down from the most significant digit
   always_comb begin
      logic z;
      z         = 1'b1;
      blank_vec = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         z            = z && (digits_reg[i*4 +: 4] == 4'd0);
         blank_vec[i] = (BLANK_LEADING != 0) && (i > DP_POS) && z;
      end
   end

   always_comb begin
      an  = '1;
      seg = '0;
      dp  = 1'b0;
      nib = '0;
      if (32'(sel) < 32'(NUM_DIGITS)) begin
         an  = ~(NUM_DIGITS'(1) << sel);
         nib = digits_reg[{sel, 2'b00} +: 4];
         seg = blank_vec[sel] ? 7'd0 : seg_code(nib);
         dp  = (32'(sel) == 32'(DP_POS));
      end
   end

   assign count     = count_reg;
   assign running   = running_reg;
   assign game_over = game_over_reg;

endmodule

// File: tb/tb_countdown_timer_sseg.sv
// Self-checking bench for countdown_timer_sseg: directed scenarios followed by
// random control pulses, all checked against a cycle-level behavioural model.
module tb_countdown_timer_sseg;

   localparam int TICK_DIV      = 20;
   localparam int START_COUNT   = 12;
   localparam int PENALTY       = 5;
   localparam int NUM_DIGITS    = 4;
   localparam int DP_POS        = 4;
   localparam int SCAN_BITS     = 4;
   localparam int BLANK_LEADING = 0;
   localparam int COUNT_W       = $clog2(START_COUNT + 1);

   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;

   logic clock   = 1'b0;
   logic reset   = 1'b0;
   logic start   = 1'b0;
   logic pause   = 1'b0;
   logic penalty = 1'b0;
   logic [6:0]            seg;
   logic                  dp;
   logic [NUM_DIGITS-1:0] an;
   logic                  game_over;
   logic                  running;
   logic [COUNT_W-1:0]    count;

   int n_cmp = 0;
   int n_err = 0;
   int m_mode, m_count, m_phase, m_scan;
   logic [6:0] seg_tab [0:9];

   countdown_timer_sseg #(
      .TICK_DIV      (TICK_DIV),
      .START_COUNT   (START_COUNT),
      .PENALTY       (PENALTY),
      .NUM_DIGITS    (NUM_DIGITS),
      .DP_POS        (DP_POS),
      .SCAN_BITS     (SCAN_BITS),
      .BLANK_LEADING (BLANK_LEADING)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .pause     (pause),
      .penalty   (penalty),
      .seg       (seg),
      .dp        (dp),
      .an        (an),
      .game_over (game_over),
      .running   (running),
      .count     (count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic logic [3:0] an_for(input int idx);
      logic [3:0] a;
      a = 4'b1111 ^ (4'b0001 << idx);
      return a;
   endfunction

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_count = START_COUNT;
      m_phase = 0;
      m_scan  = 0;
   endtask

   // One clock of game rules: tick every TICK_DIV cycles of continuous running
   task automatic model_edge(input bit s, input bit p, input bit pen);
      int sub;
      int nxt;
      sub = 0;
      if (m_mode == M_RUN && m_phase == TICK_DIV - 1) sub += 1;
      if (pen && (m_mode == M_RUN || m_mode == M_PAUSED)) sub += PENALTY;
      nxt = m_mode;
      case (m_mode)
         M_IDLE:    if (s) nxt = p ? M_PAUSED : M_RUN;
         M_RUN:     if (m_count == 0) nxt = M_EXPIRED; else if (p) nxt = M_PAUSED;
         M_PAUSED:  if (m_count == 0) nxt = M_EXPIRED; else if (s && !p) nxt = M_RUN;
         default:   if (s) nxt = M_RUN;
      endcase
      if (m_mode == M_EXPIRED && s) m_count = START_COUNT;
      else m_count = (m_count > sub) ? m_count - sub : 0;
      m_phase = (m_mode == M_RUN && nxt == M_RUN) ? (m_phase + 1) % TICK_DIV : 0;
      m_mode  = nxt;
      m_scan  = (m_scan + 1) % (1 << SCAN_BITS);
   endtask

   task automatic check_state();
      chk("count", 64'(count), 64'(m_count));
      chk("running", 64'(running), 64'(m_mode == M_RUN));
      chk("game_over", 64'(game_over), 64'(m_mode == M_EXPIRED));
      chk("an", 64'(an), 64'(an_for(m_scan >> (SCAN_BITS - 2))));
      chk("dp", 64'(dp), 64'd0);
   endtask

   task automatic step(input bit s, input bit p, input bit pen);
      start = s; pause = p; penalty = pen;
      @(posedge clock);
      model_edge(s, p, pen);
      #1;
      start = 1'b0; pause = 1'b0; penalty = 1'b0;
      check_state();
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   // Asynchronous reset: outputs must return to reset values with no clock edge
   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      model_reset();
      chk({tag, "_count"}, 64'(count), 64'(START_COUNT));
      chk({tag, "_running"}, 64'(running), 64'd0);
      chk({tag, "_game_over"}, 64'(game_over), 64'd0);
      chk({tag, "_an"}, 64'(an), 64'(4'b1110));
      chk({tag, "_seg"}, 64'(seg), 64'(seg_tab[START_COUNT % 10]));
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // Scan through every digit position and compare segments with the value
   task automatic check_display(input string tag, input int value);
      int k;
      int dig;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         k = 0;
         while (an !== an_for(d) && k < 20) begin
            step(1'b0, 1'b0, 1'b0);
            k++;
         end
         dig = (value / (10 ** d)) % 10;
         chk($sformatf("%s_an%0d", tag, d), 64'(an), 64'(an_for(d)));
         chk($sformatf("%s_seg%0d", tag, d), 64'(seg), 64'(seg_tab[dig]));
         chk($sformatf("%s_dp%0d", tag, d), 64'(dp), 64'd0);
      end
   endtask

   initial begin
      seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0000110; seg_tab[2] = 7'b1011011;
      seg_tab[3] = 7'b1001111; seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
      seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111; seg_tab[8] = 7'b1111111;
      seg_tab[9] = 7'b1101111;

      // Reset and 200 idle cycles: count held, anodes scanning
      #2;
      do_reset("por");
      idle_steps(200);
      chk("idle_count", 64'(count), 64'd12);
      chk("idle_running", 64'(running), 64'd0);
      check_display("idle_disp", 12);

      // Start and run to expiry
      step(1'b1, 1'b0, 1'b0);
      chk("start_running", 64'(running), 64'd1);
      idle_steps(19);
      chk("pre_tick_count", 64'(count), 64'd12);
      step(1'b0, 1'b0, 1'b0);
      chk("first_tick_count", 64'(count), 64'd11);
      idle_steps(220);
      chk("zero_count", 64'(count), 64'd0);
      chk("zero_no_game_over", 64'(game_over), 64'd0);
      step(1'b0, 1'b0, 1'b0);
      chk("game_over_set", 64'(game_over), 64'd1);
      idle_steps(10);
      check_display("expired_disp", 0);

      // EXPIRED ignores pause and penalty; start reloads
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      chk("exp_ignore_go", 64'(game_over), 64'd1);
      chk("exp_ignore_count", 64'(count), 64'd0);
      step(1'b1, 1'b0, 1'b0);
      chk("restart_count", 64'(count), 64'd12);
      chk("restart_running", 64'(running), 64'd1);

      // Penalties: 11 -> 6, then 4 -> 0 and expiry
      idle_steps(20);
      chk("pen_pre", 64'(count), 64'd11);
      step(1'b0, 1'b0, 1'b1);
      chk("pen_11_to_6", 64'(count), 64'd6);
      idle_steps(39);
      chk("pen_at_4", 64'(count), 64'd4);
      step(1'b0, 1'b0, 1'b1);
      chk("pen_sat_zero", 64'(count), 64'd0);
      step(1'b0, 1'b0, 1'b0);
      chk("pen_expired", 64'(game_over), 64'd1);

      // Penalty coinciding with a tick at count 7
      step(1'b1, 1'b0, 1'b0);
      idle_steps(119);
      chk("tickpen_pre", 64'(count), 64'd7);
      step(1'b0, 1'b0, 1'b1);
      chk("tickpen_count", 64'(count), 64'd1);

      // Reset mid-run at count 7 while a conversion is in flight
      do_reset("rst_a");
      step(1'b1, 1'b0, 1'b0);
      idle_steps(102);
      chk("midrun_count", 64'(count), 64'd7);
      do_reset("rst_mid");
      check_display("rst_disp", 12);

      // Pause after 30 cycles, frozen for 100, then resume
      do_reset("rst_b");
      step(1'b1, 1'b0, 1'b0);
      idle_steps(29);
      step(1'b0, 1'b1, 1'b0);
      chk("paused_running", 64'(running), 64'd0);
      idle_steps(100);
      chk("paused_frozen", 64'(count), 64'd11);
      check_display("paused_disp", 11);
      step(1'b1, 1'b0, 1'b0);
      chk("resume_running", 64'(running), 64'd1);
      idle_steps(19);
      chk("resume_pre_tick", 64'(count), 64'd11);
      step(1'b0, 1'b0, 1'b0);
      chk("resume_tick", 64'(count), 64'd10);

      // IDLE ignores penalty; start+pause from IDLE enters PAUSED
      do_reset("rst_c");
      step(1'b0, 1'b0, 1'b1);
      chk("idle_pen_ignored", 64'(count), 64'd12);
      step(1'b1, 1'b1, 1'b0);
      chk("startpause_running", 64'(running), 64'd0);
      step(1'b0, 1'b0, 1'b1);
      chk("paused_pen", 64'(count), 64'd7);
      idle_steps(10);
      check_display("paused_pen_disp", 7);
      step(1'b1, 1'b0, 1'b0);
      chk("paused_start", 64'(running), 64'd1);

      // Random control pulses against the model
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 2);
      step(1'b0, 1'b1, 1'b0);
      idle_steps(10);
      check_display("rand_disp", m_count);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/countdown_timer_sseg.md
Name: countdown_timer_sseg

Overview:
- Parametrised game countdown timer with built-in multiplexed 7-segment driver.
- Holds a binary tick count and decrements it from a prescaled clock enable. Supports start, pause, resume, penalty subtraction and restart after expiry.
- A sequential binary-to-BCD converter feeds a NUM_DIGITS anode scan.
- Sits between game-control FSM (start/pause/penalty pulses, consumes game_over) and board display pins.

Parameters:
- TICK_DIV, 5000: clock cycles per count tick; must be >= 2.
- START_COUNT, 1800000: reload value in ticks; must be < 10**NUM_DIGITS.
- PENALTY, 100: ticks removed per penalty pulse.
- NUM_DIGITS, 8: displayed digits/anodes, 1..8.
- DP_POS, 4: digit index (0 = rightmost) with decimal point lit; DP_POS >= NUM_DIGITS means none lit.
- SCAN_BITS, 6: scan counter width; top $clog2(NUM_DIGITS) bits select the digit.
- BLANK_LEADING, 0: when 1, leading zeros above DP_POS are blanked (segments off).

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous active-high reset.
- start, in, 1: one-cycle pulse; starts/resumes, or restarts after expiry.
- pause, in, 1: one-cycle pulse; pauses while running.
- penalty, in, 1: one-cycle pulse; subtract PENALTY.
- seg, out, 7: {g,f,e,d,c,b,a}, active-high.
- dp, out, 1: decimal point, active-high.
- an, out, NUM_DIGITS: anode enables, active-low, one-hot-low.
- game_over, out, 1: high in EXPIRED.
- running, out, 1: high in RUN.
- count, out, COUNT_W: current binary count; COUNT_W = $clog2(START_COUNT+1).

Behaviour:
- Reset (async): state IDLE, count = START_COUNT, prescaler = 0, scan = 0, game_over = 0, running = 0.
- On reset, the display register holds BCD of START_COUNT, so digits are valid immediately.
- FSM states: IDLE, RUN, PAUSED, EXPIRED.
  - IDLE/PAUSED + start -> RUN.
  - RUN + pause -> PAUSED.
  - EXPIRED + start -> reload START_COUNT, enter RUN.
  - start and pause in the same cycle: pause wins. RUN stays/enters PAUSED; IDLE goes to PAUSED.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; tick = (prescaler == TICK_DIV-1).
  - Held at 0 outside RUN, so resume gives a full period before the next tick.
- Tick in RUN: count <= count-1. If the new count is 0, next state is EXPIRED (game_over high the cycle after the count register reads 0).
- Penalty:
  - Accepted in RUN and PAUSED; ignored in IDLE and EXPIRED.
  - count <= max(count - PENALTY, 0). Reaching 0 -> EXPIRED.
  - Tick and penalty in the same cycle: subtract PENALTY+1, saturating at 0.
- Count never wraps below 0.
- EXPIRED: count frozen at 0; pause and penalty ignored.
- BCD conversion (sub-module, shift-add-3):
  - Launched whenever idle and count != last converted value.
  - Takes COUNT_W+1 cycles; on done, digit register updates atomically (no partial digits shown).
  - Reset mid-conversion aborts it.
  - A count change during conversion is picked up by the next launch.
  - TICK_DIV must exceed COUNT_W+2.
- Scan:
  - SCAN_BITS free-running counter; digit index = top bits; anode for index i = 0, others 1.
  - Indices >= NUM_DIGITS drive all anodes 1 and seg 0.
- Segment map (0-9), combinational on the selected digit:
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110.
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111.
  - Others = 1000000 (dash).
- dp = 1 only while the DP_POS digit is selected.

Decomposition:
- Shared package timer_pkg:
  - FSM state enum (IDLE, RUN, PAUSED, EXPIRED).
  - 7-segment digit-code constants.
  - Function for BCD width (4*NUM_DIGITS).
- Sub-module bin2bcd_seq:
  - Parameters IN_W, DIGITS.
  - Ports: clock, reset, start, bin, busy, done (one-cycle pulse), bcd.
- Top instantiates bin2bcd_seq once.

Test Plan (TICK_DIV=20, START_COUNT=12, PENALTY=5, NUM_DIGITS=4, DP_POS=4, SCAN_BITS=4, BLANK_LEADING=0):
- Reset, no start for 200 cycles -> count=12, display digits 0012, running=0, an cycles 1110, 1101, 1011, 0111 every 4 clocks.
- start pulse -> running=1; count=11 exactly 20 cycles later, 0 after 240 cycles; game_over=1 the following cycle; display 0000.
- start, pause after 30 cycles -> count=11 frozen for 100 cycles. Then start -> next decrement 20 cycles after resume.
- Running at count=11, penalty -> count=6. Penalty at 4 -> count=0, EXPIRED. Penalty coinciding with tick at 7 -> count=1.
- In EXPIRED, pause/penalty ignored; start -> count=12, RUN. start+pause same cycle from IDLE -> PAUSED.
- Assert reset mid-run (count=7) and mid-conversion -> all outputs return to reset values immediately; display shows 0012 with no glitch digits.
